// File: rtl/ir_nec_pkg.sv
// Shared NEC protocol definitions: FSM states, unit durations and small helpers.
// The receiver's timing checks use the same constants.
package ir_nec_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP,
        REP_MARK,
        REP_SPACE
    } nec_state_e;

    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int BIT0_SPACE_U = 1;
    localparam int BIT1_SPACE_U = 3;
    localparam int NBITS        = 32;

    function automatic logic is_mark(nec_state_e s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK) || (s == REP_MARK);
    endfunction

    // Length of a state in NEC units; bit marks and the stop mark are one unit.
    function automatic logic [4:0] state_units(nec_state_e s, logic one_bit);
        logic [4:0] u;
        case (s)
            LEAD_MARK, REP_MARK: u = 5'(LEAD_MARK_U);
            LEAD_SPACE:          u = 5'(LEAD_SPACE_U);
            REP_SPACE:           u = 5'(REP_SPACE_U);
            BIT_SPACE:           u = one_bit ? 5'(BIT1_SPACE_U) : 5'(BIT0_SPACE_U);
            default:             u = 5'd1;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/ir_nec_if.sv
// Control/status bundle between a frame requester (master) and the NEC transmitter (slave).
interface ir_nec_if;
    logic [15:0] code_i;
    logic        send_i;
    logic        repeat_i;
    logic        busy_o;
    logic        ir_tx_o;
    logic        ir_led_o;
    logic [7:0]  frame_cnt_o;

    modport master (
        output code_i, send_i, repeat_i,
        input  busy_o, ir_tx_o, ir_led_o, frame_cnt_o
    );

    modport slave (
        input  code_i, send_i, repeat_i,
        output busy_o, ir_tx_o, ir_led_o, frame_cnt_o
    );
endinterface

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier for the IR LED: restarts high on each mark entry, toggles every
// CARRIER_HALF cycles while enabled, held low otherwise.
module ir_carrier_gen #(
    parameter int CARRIER_HALF = 355
) (
    input  logic clk27,
    input  logic clk_reset_n,
    input  logic enable_i,
    input  logic restart_i,
    output logic ir_led_o
);
    localparam int PH_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CARRIER_HALF - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            led_q, led_d;

    always_comb begin
        phase_d = '0;
        led_d   = 1'b0;
        if (restart_i) begin
            led_d = 1'b1;
        end else if (enable_i) begin
            if (phase_q == PH_LAST) begin
                led_d = ~led_q;
            end else begin
                phase_d = phase_q + 1'b1;
                led_d   = led_q;
            end
        end
    end

    always_ff @(posedge clk27 or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            phase_q <= '0;
            led_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign ir_led_o = led_q;
endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: serialises a 16-bit address/command into an NEC frame, then
// emits repeat frames while repeat_i is held at each period end.
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CYCLES  = 15188,
    parameter int CARRIER_HALF = 355,
    parameter int FRAME_UNITS  = 192
) (
    input  logic     clk27,
    input  logic     clk_reset_n,
    ir_nec_if.slave  bus
);
    localparam logic [13:0] PRESC_LAST = 14'(UNIT_CYCLES - 1);
    localparam logic [8:0]  FRAME_END  = 9'(FRAME_UNITS);

    nec_state_e       state_q, state_d;
    logic [13:0]      presc_q, presc_d;
    logic [4:0]       unit_q, unit_d;
    logic [7:0]       period_q, period_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             tx_q, busy_q;
    logic             tick, unit_done, period_done, entering, led;

    assign tick        = (state_q != IDLE) && (presc_q == PRESC_LAST);
    assign unit_done   = tick && (unit_q == state_units(state_q, shift_q[0]) - 5'd1);
    assign period_done = tick && (({1'b0, period_q} + 9'd1) >= FRAME_END);
    assign entering    = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (bus.send_i)  state_d = LEAD_MARK;
            LEAD_MARK:  if (unit_done)   state_d = LEAD_SPACE;
            LEAD_SPACE: if (unit_done)   state_d = BIT_MARK;
            BIT_MARK:   if (unit_done)   state_d = BIT_SPACE;
            BIT_SPACE:  if (unit_done)   state_d = (bit_cnt_q == 5'(NBITS - 1)) ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (unit_done)   state_d = GAP;
            GAP:        if (period_done) state_d = bus.repeat_i ? REP_MARK : IDLE;
            REP_MARK:   if (unit_done)   state_d = REP_SPACE;
            REP_SPACE:  if (unit_done)   state_d = STOP_MARK;
            default:                     state_d = IDLE;
        endcase
    end

    // Unit timing restarts on every state change; the period counter spans the
    // whole frame from the leader (or repeat) mark so GAP can pad to FRAME_UNITS.
    always_comb begin
        presc_d     = '0;
        unit_d      = '0;
        period_d    = period_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (!entering && (state_q != IDLE)) begin
            presc_d = tick ? 14'd0 : presc_q + 14'd1;
            unit_d  = tick ? unit_q + 5'd1 : unit_q;
        end
        if (entering && ((state_d == LEAD_MARK) || (state_d == REP_MARK))) begin
            period_d = '0;
        end else if (tick) begin
            period_d = period_q + 8'd1;
        end
        if ((state_q == IDLE) && (state_d == LEAD_MARK)) begin
            shift_d   = {~bus.code_i[7:0], bus.code_i[7:0], ~bus.code_i[15:8], bus.code_i[15:8]};
            bit_cnt_d = '0;
        end else if ((state_q == BIT_SPACE) && entering) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if ((state_q == STOP_MARK) && (state_d == GAP)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk27 or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            unit_q      <= '0;
            period_q    <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            unit_q      <= unit_d;
            period_q    <= period_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            tx_q        <= ~is_mark(state_d);
            busy_q      <= (state_d != IDLE);
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_carrier (
        .clk27       (clk27),
        .clk_reset_n (clk_reset_n),
        .enable_i    (is_mark(state_d)),
        .restart_i   (is_mark(state_d) && !is_mark(state_q)),
        .ir_led_o    (led)
    );

    assign bus.busy_o      = busy_q;
    assign bus.ir_tx_o     = tx_q;
    assign bus.ir_led_o    = led;
    assign bus.frame_cnt_o = frame_cnt_q;
endmodule
